seg7_scan_mux: RTL and testbench
================================

// Module: seg7_scan_mux
// PURPOSE
//  Downstream of the vending display BCD stage: takes its four 4-bit digit codes and
//  time-multiplexes them onto one common 7-segment bus plus four digit enables.
//  Snapshots digits once per frame (no tearing), decodes digits and glyphs, optional
//  leading-zero blanking, anti-ghost guard interval, frame-rate blink for alerts.
// PARAMETERS
//  REFRESH_DIV   50000  clk cycles per digit slot; must be >= GUARD_CYCLES+2
//  GUARD_CYCLES  4      cycles at start of each slot with all anodes off
//  BLINK_FRAMES  64     frames per blink half-period; must be >= 1
//  SEG_ACT_LOW   1      1: seg outputs active-low
//  AN_ACT_LOW    1      1: an outputs active-low
// PORTS
//  clk         in   1  system clock
//  rst_n       in   1  synchronous reset, active-low
//  digit3      in   4  leftmost digit code (hundreds / glyph)
//  digit2      in   4  digit code
//  digit1      in   4  digit code
//  digit0      in   4  rightmost digit code
//  lzb_en      in   1  leading-zero blanking enable
//  blink_en    in   1  blink whole display (e.g. error state)
//  seg         out  7  segments {g,f,e,d,c,b,a}, polarity per SEG_ACT_LOW
//  an          out  4  digit enables, an[i] drives digit i, polarity per AN_ACT_LOW
//  frame_tick  out  1  1-cycle pulse on the cycle the snapshot is taken
// BEHAVIOUR
//  Clock/reset: single clock clk; reset rst_n is synchronous, active-low; all regs update on posedge clk only.
//  - Reset: presc=0, idx=0, snap[3:0]=4'hF each, blink_cnt=0, phase=on, frame_tick=0,
//    an=all off, seg=all off. Reset mid-operation: same values on next edge.
//  - presc counts 0..REFRESH_DIV-1, wraps to 0; on wrap idx increments 0->1->2->3->0.
//  - Frame wrap (presc==DIV-1 && idx==3): next edge idx=0, snap<=digit3..0,
//    frame_tick=1 for that one cycle. Inputs otherwise ignored. First real data
//    appears after first frame wrap (4*DIV cycles after reset release).
//  - Decode (active-high, bit0=a): 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F
//    A('r'):50 B('b'):7C C:39 D('d'):5E E:79 F(blank):00.
//  - LZB (lzb_en=1, evaluated on snap): digit3 blanked if snap3==0; digit2 blanked
//    if snap3==0 && snap2==0. digit1/digit0 never blanked. Blanked = seg 00, anode on.
//  - an/seg registered: value at edge N+1 = f(presc,idx,snap,phase at cycle N), 1-cycle latency.
//    presc<GUARD_CYCLES or phase=off -> all anodes off, seg off;
//    else only an[idx] on, seg=decode(snap[idx]) (after LZB).
//  - Blink: blink_en=0 -> blink_cnt=0, phase=on (synchronously). blink_en=1 -> each
//    frame wrap increments blink_cnt; at count BLINK_FRAMES-1 wraps to 0 and phase toggles.
//  - Polarity applied last: active-low outputs are bitwise inverted.
//  - Never more than one anode active in any cycle.
// TESTING
//  1 rst_n=0 any inputs -> next edge an=4'b1111, seg=7'h7F, frame_tick=0 (default params).
//  2 DIV=8 GUARD=2, digits 1,2,5,0 -> frame_tick at cycle 32; slot0 an=1110 seg=7'h40
//    for slot cycles 2..7 (with 1-cycle lag), an=1111 cycles 0..1; slot3 seg=7'h79 ('1').
//  3 digits E,A,A,F -> slots 3,2,1,0 seg = ~79,~50,~50,~00; slot0 anode on, segs dark.
//  4 lzb_en=1: 0,0,5,0 -> slots 3,2 dark, slot1 '5'; 0,5,0,0 -> only slot3 dark.
//  5 change digits mid-frame -> an/seg unchanged until next frame_tick, then new values.
//  6 BLINK_FRAMES=2 blink_en=1 -> 2 frames on, 2 frames all-off, repeat; drop blink_en ->
//    display on next cycle; assert rst_n low mid-slot -> reset values next edge.

Source files
------------

// File: rtl/seg7_scan_mux.sv
// -----------------------------------------------------------------------------
// seg7_scan_mux
//   Time-multiplexes four 4-bit digit codes onto one shared 7-segment bus plus
//   four digit enables. The digit codes are captured once per frame so a digit
//   never changes partway through a scan. Each digit slot begins with a guard
//   interval that keeps every anode off, so the previous digit's segments do not
//   ghost onto the next one. The whole display can blink at a frame-based rate.
//
// Parameters
//   REFRESH_DIV   clk cycles per digit slot (>= GUARD_CYCLES+2)
//   GUARD_CYCLES  cycles at the start of each slot with all anodes off
//   BLINK_FRAMES  frames per blink half-period (>= 1)
//   SEG_ACT_LOW   1: seg outputs are active-low
//   AN_ACT_LOW    1: an outputs are active-low
//
// Ports
//   clk         in   system clock
//   rst_n       in   synchronous reset, active-low
//   digit3..0   in   digit codes, digit3 leftmost
//   lzb_en      in   leading-zero blanking enable (digit3, digit2 only)
//   blink_en    in   blink the whole display
//   seg         out  segments {g,f,e,d,c,b,a}
//   an          out  digit enables, an[i] drives digit i
//   frame_tick  out  1-cycle pulse in the cycle after the snapshot edge
// -----------------------------------------------------------------------------
module seg7_scan_mux #(
  parameter int REFRESH_DIV  = 50000,
  parameter int GUARD_CYCLES = 4,
  parameter int BLINK_FRAMES = 64,
  parameter int SEG_ACT_LOW  = 1,
  parameter int AN_ACT_LOW   = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] digit3,
  input  logic [3:0] digit2,
  input  logic [3:0] digit1,
  input  logic [3:0] digit0,
  input  logic       lzb_en,
  input  logic       blink_en,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       frame_tick
);

  localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [PW-1:0] PRESC_MAX  = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] GUARD_END  = PW'(GUARD_CYCLES);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

  localparam logic [6:0] SEG_OFF = (SEG_ACT_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [3:0] AN_OFF  = (AN_ACT_LOW  != 0) ? 4'hF  : 4'h0;

  // Active-high glyph table; bit0 = segment a.
  function automatic logic [6:0] decode7(input logic [3:0] code);
    logic [6:0] s;
    case (code)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h50;  // 'r'
      4'hB: s = 7'h7C;  // 'b'
      4'hC: s = 7'h39;  // 'C'
      4'hD: s = 7'h5E;  // 'd'
      4'hE: s = 7'h79;  // 'E'
      default: s = 7'h00;  // 0xF is the blank glyph
    endcase
    return s;
  endfunction

  function automatic logic [6:0] seg_pol(input logic [6:0] s);
    return (SEG_ACT_LOW != 0) ? ~s : s;
  endfunction

  function automatic logic [3:0] an_pol(input logic [3:0] a);
    return (AN_ACT_LOW != 0) ? ~a : a;
  endfunction

  logic [PW-1:0]      presc_q, presc_d;
  logic [1:0]         idx_q, idx_d;
  logic [3:0][3:0]    snap_q, snap_d;
  logic [BW-1:0]      blink_cnt_q, blink_cnt_d;
  logic               phase_q, phase_d;     // 1 = display on
  logic               frame_tick_q, frame_tick_d;
  logic [3:0]         an_q, an_d;
  logic [6:0]         seg_q, seg_d;

  logic               presc_wrap;
  logic               frame_wrap;
  logic               lz_blank;
  logic [3:0]         cur_code;
  logic [3:0]         an_on;
  logic [6:0]         seg_on;

  // Slot timing, frame snapshot and blink phase
  always_comb begin
    presc_wrap   = (presc_q == PRESC_MAX);
    frame_wrap   = presc_wrap && (idx_q == 2'd3);

    presc_d      = presc_wrap ? '0 : presc_q + PW'(1);
    idx_d        = presc_wrap ? idx_q + 2'd1 : idx_q;
    snap_d       = frame_wrap ? {digit3, digit2, digit1, digit0} : snap_q;
    frame_tick_d = frame_wrap;

    blink_cnt_d  = blink_cnt_q;
    phase_d      = phase_q;
    if (!blink_en) begin
      // Leaving blink mode always restores a lit display immediately.
      blink_cnt_d = '0;
      phase_d     = 1'b1;
    end else if (frame_wrap) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BW'(1);
      end
    end
  end

  // Display decode: anode/segment values registered for the next cycle
  always_comb begin
    cur_code = snap_q[idx_q];
    // Leading zeros are blanked only on the two leftmost digits; the blank
    // still lights the anode so the scan duty stays uniform.
    lz_blank = lzb_en &&
               (((idx_q == 2'd3) && (snap_q[3] == 4'h0)) ||
                ((idx_q == 2'd2) && (snap_q[3] == 4'h0) && (snap_q[2] == 4'h0)));

    an_on  = 4'h0;
    seg_on = 7'h00;
    if ((presc_q >= GUARD_END) && phase_q) begin
      an_on  = 4'b0001 << idx_q;
      seg_on = lz_blank ? 7'h00 : decode7(cur_code);
    end

    an_d  = an_pol(an_on);
    seg_d = seg_pol(seg_on);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_q      <= '0;
      idx_q        <= 2'd0;
      snap_q       <= {4{4'hF}};
      blink_cnt_q  <= '0;
      phase_q      <= 1'b1;
      frame_tick_q <= 1'b0;
      an_q         <= AN_OFF;
      seg_q        <= SEG_OFF;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      snap_q       <= snap_d;
      blink_cnt_q  <= blink_cnt_d;
      phase_q      <= phase_d;
      frame_tick_q <= frame_tick_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg7_scan_mux.sv
module tb_seg7_scan_mux;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] digit3, digit2, digit1, digit0;
  logic       lzb_en, blink_en;
  logic [6:0] seg, seg_dflt;
  logic [3:0] an, an_dflt;
  logic       frame_tick, frame_tick_dflt;

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;
  bit mon_en  = 1'b0;

  always #5 clk = ~clk;

  seg7_scan_mux #(
    .REFRESH_DIV (8),
    .GUARD_CYCLES(2),
    .BLINK_FRAMES(2),
    .SEG_ACT_LOW (1),
    .AN_ACT_LOW  (1)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .digit3    (digit3),
    .digit2    (digit2),
    .digit1    (digit1),
    .digit0    (digit0),
    .lzb_en    (lzb_en),
    .blink_en  (blink_en),
    .seg       (seg),
    .an        (an),
    .frame_tick(frame_tick)
  );

  // Default-parameter instance, used for the reset-value check only.
  seg7_scan_mux u_dflt (
    .clk       (clk),
    .rst_n     (rst_n),
    .digit3    (digit3),
    .digit2    (digit2),
    .digit1    (digit1),
    .digit0    (digit0),
    .lzb_en    (lzb_en),
    .blink_en  (blink_en),
    .seg       (seg_dflt),
    .an        (an_dflt),
    .frame_tick(frame_tick_dflt)
  );

  // At most one anode may be active in any cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      n_total++;
      if (!$onehot0(~an)) $display("FAIL onehot_an t=%0t an=%b required at most one low bit", $time, an);
      else n_pass++;
    end
  end

  // Advance to cycle c (c = number of edges since reset release), sample 1ns after the edge.
  task automatic go_to(input int c);
    while (cyc < c) begin
      @(posedge clk);
      cyc++;
    end
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; digit3 = 4'h3; digit2 = 4'h7; digit1 = 4'h1; digit0 = 4'h8;
    lzb_en = 1'b0; blink_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_total++;
    if ({an_dflt, seg_dflt, frame_tick_dflt} !== {4'hF, 7'h7F, 1'b0})
      $display("FAIL rst_dflt got an=%b seg=%h ft=%b required an=1111 seg=7f ft=0", an_dflt, seg_dflt, frame_tick_dflt);
    else n_pass++;
    n_total++;
    if ({an, seg, frame_tick} !== {4'hF, 7'h7F, 1'b0})
      $display("FAIL rst_dut got an=%b seg=%h ft=%b required an=1111 seg=7f ft=0", an, seg, frame_tick);
    else n_pass++;
    blink_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    mon_en = 1'b1;
  endtask

  task automatic test_frame_decode;
    digit3 = 4'h1; digit2 = 4'h2; digit1 = 4'h5; digit0 = 4'h0;
    go_to(3);
    n_total++; if ({an, seg} !== {4'b1110, 7'h7F}) $display("FAIL blank_snap got %b/%h required 1110/7f", an, seg); else n_pass++;
    go_to(31);
    n_total++; if (frame_tick !== 1'b0) $display("FAIL ft_pre got %b required 0", frame_tick); else n_pass++;
    go_to(32);
    n_total++; if (frame_tick !== 1'b1) $display("FAIL ft_32 got %b required 1", frame_tick); else n_pass++;
    go_to(33);
    n_total++; if (frame_tick !== 1'b0) $display("FAIL ft_post got %b required 0", frame_tick); else n_pass++;
    go_to(34);
    n_total++; if ({an, seg} !== {4'b1111, 7'h7F}) $display("FAIL guard0 got %b/%h required 1111/7f", an, seg); else n_pass++;
    go_to(35);
    n_total++; if ({an, seg} !== {4'b1110, 7'h40}) $display("FAIL slot0_first got %b/%h required 1110/40", an, seg); else n_pass++;
    go_to(40);
    n_total++; if ({an, seg} !== {4'b1110, 7'h40}) $display("FAIL slot0_last got %b/%h required 1110/40", an, seg); else n_pass++;
    go_to(41);
    n_total++; if ({an, seg} !== {4'b1111, 7'h7F}) $display("FAIL guard1 got %b/%h required 1111/7f", an, seg); else n_pass++;
    go_to(43);
    n_total++; if ({an, seg} !== {4'b1101, 7'h12}) $display("FAIL slot1_5 got %b/%h required 1101/12", an, seg); else n_pass++;
    go_to(51);
    n_total++; if ({an, seg} !== {4'b1011, 7'h24}) $display("FAIL slot2_2 got %b/%h required 1011/24", an, seg); else n_pass++;
    go_to(60);
    n_total++; if ({an, seg} !== {4'b0111, 7'h79}) $display("FAIL slot3_1 got %b/%h required 0111/79", an, seg); else n_pass++;
  endtask

  task automatic test_glyphs;
    digit3 = 4'hE; digit2 = 4'hA; digit1 = 4'hA; digit0 = 4'hF;
    go_to(99);
    n_total++; if ({an, seg} !== {4'b1110, 7'h7F}) $display("FAIL glyph_blank got %b/%h required 1110/7f", an, seg); else n_pass++;
    go_to(107);
    n_total++; if ({an, seg} !== {4'b1101, 7'h2F}) $display("FAIL glyph_r1 got %b/%h required 1101/2f", an, seg); else n_pass++;
    go_to(115);
    n_total++; if ({an, seg} !== {4'b1011, 7'h2F}) $display("FAIL glyph_r2 got %b/%h required 1011/2f", an, seg); else n_pass++;
    go_to(123);
    n_total++; if ({an, seg} !== {4'b0111, 7'h06}) $display("FAIL glyph_E got %b/%h required 0111/06", an, seg); else n_pass++;
  endtask

  task automatic test_lzb;
    lzb_en = 1'b1;
    digit3 = 4'h0; digit2 = 4'h0; digit1 = 4'h5; digit0 = 4'h0;
    go_to(163);
    n_total++; if ({an, seg} !== {4'b1110, 7'h40}) $display("FAIL lzbA_s0 got %b/%h required 1110/40", an, seg); else n_pass++;
    go_to(171);
    n_total++; if ({an, seg} !== {4'b1101, 7'h12}) $display("FAIL lzbA_s1 got %b/%h required 1101/12", an, seg); else n_pass++;
    go_to(179);
    n_total++; if ({an, seg} !== {4'b1011, 7'h7F}) $display("FAIL lzbA_s2 got %b/%h required 1011/7f", an, seg); else n_pass++;
    go_to(187);
    n_total++; if ({an, seg} !== {4'b0111, 7'h7F}) $display("FAIL lzbA_s3 got %b/%h required 0111/7f", an, seg); else n_pass++;
    digit3 = 4'h0; digit2 = 4'h5; digit1 = 4'h0; digit0 = 4'h0;
    go_to(195);
    n_total++; if ({an, seg} !== {4'b1110, 7'h40}) $display("FAIL lzbB_s0 got %b/%h required 1110/40", an, seg); else n_pass++;
    go_to(203);
    n_total++; if ({an, seg} !== {4'b1101, 7'h40}) $display("FAIL lzbB_s1 got %b/%h required 1101/40", an, seg); else n_pass++;
    go_to(211);
    n_total++; if ({an, seg} !== {4'b1011, 7'h12}) $display("FAIL lzbB_s2 got %b/%h required 1011/12", an, seg); else n_pass++;
    go_to(219);
    n_total++; if ({an, seg} !== {4'b0111, 7'h7F}) $display("FAIL lzbB_s3 got %b/%h required 0111/7f", an, seg); else n_pass++;
  endtask

  task automatic test_snapshot;
    go_to(230);
    digit3 = 4'h9; digit2 = 4'h8; digit1 = 4'h7; digit0 = 4'h6;
    go_to(235);
    n_total++; if ({an, seg} !== {4'b1101, 7'h40}) $display("FAIL snap_hold_s1 got %b/%h required 1101/40", an, seg); else n_pass++;
    go_to(243);
    n_total++; if ({an, seg} !== {4'b1011, 7'h12}) $display("FAIL snap_hold_s2 got %b/%h required 1011/12", an, seg); else n_pass++;
    go_to(251);
    n_total++; if ({an, seg} !== {4'b0111, 7'h7F}) $display("FAIL snap_hold_s3 got %b/%h required 0111/7f", an, seg); else n_pass++;
    go_to(255);
    n_total++; if (frame_tick !== 1'b0) $display("FAIL snap_ft_pre got %b required 0", frame_tick); else n_pass++;
    go_to(256);
    n_total++; if (frame_tick !== 1'b1) $display("FAIL snap_ft got %b required 1", frame_tick); else n_pass++;
    go_to(267);
    n_total++; if ({an, seg} !== {4'b1101, 7'h78}) $display("FAIL snap_new_s1 got %b/%h required 1101/78", an, seg); else n_pass++;
    go_to(275);
    n_total++; if ({an, seg} !== {4'b1011, 7'h00}) $display("FAIL snap_new_s2 got %b/%h required 1011/00", an, seg); else n_pass++;
    go_to(283);
    n_total++; if ({an, seg} !== {4'b0111, 7'h10}) $display("FAIL snap_new_s3 got %b/%h required 0111/10", an, seg); else n_pass++;
  endtask

  task automatic test_blink;
    go_to(290);
    blink_en = 1'b1;
    go_to(323);
    n_total++; if ({an, seg} !== {4'b1110, 7'h02}) $display("FAIL blink_on1 got %b/%h required 1110/02", an, seg); else n_pass++;
    go_to(352);
    n_total++; if (frame_tick !== 1'b1) $display("FAIL blink_ft got %b required 1", frame_tick); else n_pass++;
    go_to(355);
    n_total++; if ({an, seg} !== {4'b1111, 7'h7F}) $display("FAIL blink_off1 got %b/%h required 1111/7f", an, seg); else n_pass++;
    go_to(400);
    n_total++; if ({an, seg} !== {4'b1111, 7'h7F}) $display("FAIL blink_off2 got %b/%h required 1111/7f", an, seg); else n_pass++;
    go_to(419);
    n_total++; if ({an, seg} !== {4'b1110, 7'h02}) $display("FAIL blink_on2 got %b/%h required 1110/02", an, seg); else n_pass++;
    go_to(484);
    n_total++; if ({an, seg} !== {4'b1111, 7'h7F}) $display("FAIL blink_off3 got %b/%h required 1111/7f", an, seg); else n_pass++;
    blink_en = 1'b0;
    go_to(485);
    n_total++; if ({an, seg} !== {4'b1111, 7'h7F}) $display("FAIL blink_drop_lag got %b/%h required 1111/7f", an, seg); else n_pass++;
    go_to(486);
    n_total++; if ({an, seg} !== {4'b1110, 7'h02}) $display("FAIL blink_drop_on got %b/%h required 1110/02", an, seg); else n_pass++;
  endtask

  task automatic test_reset_mid;
    go_to(487);
    rst_n = 1'b0;
    go_to(488);
    n_total++;
    if ({an, seg, frame_tick} !== {4'hF, 7'h7F, 1'b0})
      $display("FAIL rst_mid got an=%b seg=%h ft=%b required an=1111 seg=7f ft=0", an, seg, frame_tick);
    else n_pass++;
    rst_n = 1'b1;
    cyc = 0;
    go_to(3);
    n_total++; if ({an, seg} !== {4'b1110, 7'h7F}) $display("FAIL rst_mid_snap got %b/%h required 1110/7f", an, seg); else n_pass++;
    go_to(31);
    n_total++; if (frame_tick !== 1'b0) $display("FAIL rst_mid_ft_pre got %b required 0", frame_tick); else n_pass++;
    go_to(32);
    n_total++; if (frame_tick !== 1'b1) $display("FAIL rst_mid_ft got %b required 1", frame_tick); else n_pass++;
    go_to(35);
    n_total++; if ({an, seg} !== {4'b1110, 7'h02}) $display("FAIL rst_mid_data got %b/%h required 1110/02", an, seg); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_frame_decode();
    test_glyphs();
    test_lzb();
    test_snapshot();
    test_blink();
    test_reset_mid();
    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
